// File: rtl/cordic_pipe_param.sv
// Fully pipelined CORDIC, one sample per clock. Each sample picks its own mode:
//   mode=0 rotate: (i,q) rotated by phase_in; phase_out is the residual angle (about 0)
//   mode=1 vector: iout = gain * |(i,q)|, qout about 0, phase_out = atan2(q,i)
// Handshake: in_valid qualifies i_in/q_in/phase_in/mode on the clk edge where it is
// high; out_valid is in_valid delayed STAGES+2 clocks. There is no ready/backpressure.
// Outputs hold their last value while out_valid is low.
// The x/y datapath carries one guard bit above DW, so a full-scale input vector
// (magnitude sqrt(2)*K above full scale) never wraps; the output saturation is the
// only clipping.
module cordic_pipe_param #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 18,
    parameter int DW      = 20,
    parameter int PHASE_W = 20,
    parameter int STAGES  = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               mode,
    input  logic [IN_W-1:0]    i_in,
    input  logic [IN_W-1:0]    q_in,
    input  logic [PHASE_W-1:0] phase_in,
    output logic               out_valid,
    output logic [OUT_W-1:0]   iout,
    output logic [OUT_W-1:0]   qout,
    output logic [PHASE_W-1:0] phase_out
);

    if (STAGES < 8 || STAGES > 24 || STAGES > PHASE_W) begin : g_bad_stages
        $error("cordic_pipe_param: STAGES must lie in 8..min(24,PHASE_W)");
    end
    if (DW < OUT_W + 1 || DW < IN_W + 2 || PHASE_W > 32) begin : g_bad_widths
        $error("cordic_pipe_param: need DW >= OUT_W+1, DW >= IN_W+2, PHASE_W <= 32");
    end

    localparam int XW     = DW + 1;
    localparam int RW     = XW + 1;
    localparam int SH_IN  = DW - IN_W - 1;
    localparam int SH_OUT = DW - OUT_W;

    localparam logic [PHASE_W-1:0]  PI_Z = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam logic signed [RW-1:0] RND  = RW'(1) <<< (SH_OUT - 1);
    localparam logic signed [RW-1:0] OMAX = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] OMIN = -OMAX - RW'(1);

    // atan(2^-k) at pi = 2^31, rescaled to pi = 2^(PHASE_W-1) with round-half-up
    function automatic logic [23:0][PHASE_W-1:0] build_atan();
        logic [23:0][31:0]         raw;
        logic [23:0][PHASE_W-1:0]  tab;
        logic [32:0]               t;
        int                        sh;
        raw[0]  = 32'd536870912; raw[1]  = 32'd316933406; raw[2]  = 32'd167458907;
        raw[3]  = 32'd85004756;  raw[4]  = 32'd42667331;  raw[5]  = 32'd21354465;
        raw[6]  = 32'd10679838;  raw[7]  = 32'd5340245;   raw[8]  = 32'd2670163;
        raw[9]  = 32'd1335087;   raw[10] = 32'd667544;    raw[11] = 32'd333772;
        raw[12] = 32'd166886;    raw[13] = 32'd83443;     raw[14] = 32'd41722;
        raw[15] = 32'd20861;     raw[16] = 32'd10430;     raw[17] = 32'd5215;
        raw[18] = 32'd2608;      raw[19] = 32'd1304;      raw[20] = 32'd652;
        raw[21] = 32'd326;       raw[22] = 32'd163;       raw[23] = 32'd81;
        sh = 32 - PHASE_W;
        for (int k = 0; k < 24; k++) begin
            t      = ({1'b0, raw[k]} + ((33'd1 << sh) >> 1)) >> sh;
            tab[k] = t[PHASE_W-1:0];
        end
        return tab;
    endfunction

    localparam logic [23:0][PHASE_W-1:0] ANG = build_atan();

    logic signed [XW-1:0]  x_r [0:STAGES];
    logic signed [XW-1:0]  y_r [0:STAGES];
    logic [PHASE_W-1:0]    z_r [0:STAGES];
    logic [STAGES-1:0]     m_r;
    logic [STAGES:0]       v_r;
    logic [STAGES-1:0]     d_pos;

    logic signed [XW-1:0]  x_ext, y_ext, x_in0, y_in0;
    logic [PHASE_W-1:0]    z_in0;
    logic                  flip;

    // Pre-rotation by pi so the remaining angle is within CORDIC convergence range
    always_comb begin
        x_ext = {{(XW-IN_W){i_in[IN_W-1]}}, i_in} <<< SH_IN;
        y_ext = {{(XW-IN_W){q_in[IN_W-1]}}, q_in} <<< SH_IN;
        flip  = mode ? i_in[IN_W-1] : (phase_in[PHASE_W-1] ^ phase_in[PHASE_W-2]);
        x_in0 = flip ? -x_ext : x_ext;
        y_in0 = flip ? -y_ext : y_ext;
        if (mode) z_in0 = flip ? PI_Z : '0;
        else      z_in0 = flip ? (phase_in ^ PI_Z) : phase_in;
    end

    // Direction of each micro-rotation: drive y to 0 (vector) or z to 0 (rotate)
    always_comb begin
        d_pos = '0;
        for (int k = 0; k < STAGES; k++)
            d_pos[k] = m_r[k] ? y_r[k][XW-1] : ~z_r[k][PHASE_W-1];
    end

    // Data pipeline: input register followed by STAGES micro-rotation registers
    always_ff @(posedge clk) begin
        x_r[0] <= x_in0;
        y_r[0] <= y_in0;
        z_r[0] <= z_in0;
        m_r    <= {m_r[STAGES-2:0], mode};
        for (int k = 0; k < STAGES; k++) begin
            if (d_pos[k]) begin
                x_r[k+1] <= x_r[k] - (y_r[k] >>> k);
                y_r[k+1] <= y_r[k] + (x_r[k] >>> k);
                z_r[k+1] <= z_r[k] - ANG[k];
            end else begin
                x_r[k+1] <= x_r[k] + (y_r[k] >>> k);
                y_r[k+1] <= y_r[k] - (x_r[k] >>> k);
                z_r[k+1] <= z_r[k] + ANG[k];
            end
        end
    end

    // Valid bits travel alongside the data; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_r <= '0;
        else     v_r <= {v_r[STAGES-1:0], in_valid};
    end

    logic signed [RW-1:0] x_wide, y_wide, x_rnd, y_rnd;
    logic [OUT_W-1:0]     x_sat, y_sat;

    // Round half-up to OUT_W and saturate
    always_comb begin
        x_wide = RW'(x_r[STAGES]);
        y_wide = RW'(y_r[STAGES]);
        x_rnd  = (x_wide + RND) >>> SH_OUT;
        y_rnd  = (y_wide + RND) >>> SH_OUT;
        if (x_rnd > OMAX)      x_sat = OMAX[OUT_W-1:0];
        else if (x_rnd < OMIN) x_sat = OMIN[OUT_W-1:0];
        else                   x_sat = x_rnd[OUT_W-1:0];
        if (y_rnd > OMAX)      y_sat = OMAX[OUT_W-1:0];
        else if (y_rnd < OMIN) y_sat = OMIN[OUT_W-1:0];
        else                   y_sat = y_rnd[OUT_W-1:0];
    end

    // Output register; z accumulated this way already equals atan2(q,i) in vector mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            iout      <= '0;
            qout      <= '0;
            phase_out <= '0;
        end else begin
            out_valid <= v_r[STAGES];
            if (v_r[STAGES]) begin
                iout      <= x_sat;
                qout      <= y_sat;
                phase_out <= z_r[STAGES];
            end
        end
    end

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Bench for cordic_pipe_param at default parameters: directed vector table,
// randomized mixed-mode stream checked against a floating-point model, and
// reset-in-flight sequence.
`timescale 1ns/1ps
module tb_cordic_pipe_param;
    localparam int IN_W = 16, OUT_W = 18, DW = 20, PHASE_W = 20, STAGES = 17;
    localparam int LAT  = STAGES + 2;
    localparam int SW   = 1 + 2*IN_W + PHASE_W;
    localparam int HN   = 4096;
    localparam real PI  = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               mode = 1'b0;
    logic [IN_W-1:0]    i_in = '0;
    logic [IN_W-1:0]    q_in = '0;
    logic [PHASE_W-1:0] phase_in = '0;
    logic               out_valid;
    logic [OUT_W-1:0]   iout, qout;
    logic [PHASE_W-1:0] phase_out;

    cordic_pipe_param #(.IN_W(IN_W), .OUT_W(OUT_W), .DW(DW), .PHASE_W(PHASE_W),
                        .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
        .i_in(i_in), .q_in(q_in), .phase_in(phase_in),
        .out_valid(out_valid), .iout(iout), .qout(qout), .phase_out(phase_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit hist [0:HN-1];
    logic [SW-1:0] exp_q[$];
    real gain;

    // ---------------- check helpers ----------------
    task automatic check(input string nm, input longint act, input longint exp, input longint tol);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic check_ph(input string nm, input logic [PHASE_W-1:0] act, input int exp);
        logic [PHASE_W-1:0] dv;
        int d;
        dv = act - PHASE_W'(exp);
        d  = int'($signed(dv));
        if (d < 0) d = -d;
        total++;
        if (d > 16) begin
            bad++;
            $display("FAIL %s: got phase %0d want %0d (tol 16)", nm, int'($signed(act)), exp);
        end
    endtask

    function automatic int so(input logic [OUT_W-1:0] v);
        return int'($signed(v));
    endfunction

    // ---------------- reference model ----------------
    function automatic int sat_round(input real v);
        real r;
        r = $floor(v + 0.5);
        if (r > real'((1 << (OUT_W-1)) - 1)) r = real'((1 << (OUT_W-1)) - 1);
        if (r < -real'(1 << (OUT_W-1)))      r = -real'(1 << (OUT_W-1));
        return int'(r);
    endfunction

    function automatic void model(input logic [SW-1:0] s, output int ei, output int eq, output int ep);
        logic m;
        int iv, qv, pv;
        real p, a;
        m  = s[SW-1];
        iv = int'($signed(s[SW-2 -: IN_W]));
        qv = int'($signed(s[SW-2-IN_W -: IN_W]));
        pv = int'($signed(s[PHASE_W-1:0]));
        if (!m) begin
            p  = real'(pv) * PI / real'(1 << (PHASE_W-1));
            ei = sat_round(gain * (real'(iv) * $cos(p) - real'(qv) * $sin(p)));
            eq = sat_round(gain * (real'(iv) * $sin(p) + real'(qv) * $cos(p)));
            ep = 0;
        end else begin
            ei = sat_round(gain * $sqrt(real'(iv) * real'(iv) + real'(qv) * real'(qv)));
            eq = 0;
            a  = $atan2(real'(qv), real'(iv)) * real'(1 << (PHASE_W-1)) / PI;
            ep = int'($floor(a + 0.5));
            if (ep >= (1 << (PHASE_W-1))) ep = ep - (1 << PHASE_W);
        end
    endfunction

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        if (cyc < HN) hist[cyc] = in_valid && !rst;
        if (in_valid && !rst) exp_q.push_back({mode, i_in, q_in, phase_in});
        cyc = cyc + 1;
    end

    always @(posedge rst) begin
        for (int k = 0; k < HN; k++) hist[k] = 1'b0;
        exp_q.delete();
    end

    always @(negedge clk) begin : mon
        int idx, ei, eq, ep;
        logic ev;
        logic [SW-1:0] s;
        idx = cyc - LAT;
        ev  = (idx >= 0 && idx < HN) ? hist[idx] : 1'b0;
        check_bit("out_valid_timing", out_valid, ev);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0, 0);
            end else begin
                s = exp_q.pop_front();
                model(s, ei, eq, ep);
                check("model_iout", so(iout), ei, 3);
                check("model_qout", so(qout), eq, 3);
                check_ph("model_phase", phase_out, ep);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic m, input int i, input int q, input int ph);
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode     = m;
        i_in     = i[IN_W-1:0];
        q_in     = q[IN_W-1:0];
        phase_in = ph[PHASE_W-1:0];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // clocks from the drive edge of a single sample to its out_valid
    task automatic wait_out(output int n);
        n = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic gen(input logic m, output int i, output int q, output int ph);
        int tries;
        i = int'($urandom_range(65535)) - 32768;
        q = int'($urandom_range(65535)) - 32768;
        tries = 0;
        while (m && (longint'(i) * i + longint'(q) * q) < 64'd256000000 && tries < 100) begin
            i = int'($urandom_range(65535)) - 32768;
            q = int'($urandom_range(65535)) - 32768;
            tries++;
        end
        ph = int'($urandom_range((1 << PHASE_W) - 1));
    endtask

    typedef struct {
        logic m;
        int   i;
        int   q;
        int   ph;
        int   ei;
        int   eq;
        int   ep;
    } vec_t;

    vec_t tab [10];

    initial begin
        int n, cnt, vi, vq, vp;
        real k_gain;

        k_gain = 1.0;
        for (int k = 0; k < STAGES; k++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * k));
        gain = k_gain * real'(1 << (DW-IN_W-1)) / real'(1 << (DW-OUT_W));

        tab[0] = '{1'b0,  16383,      0,       0,  53957,       0,       0};
        tab[1] = '{1'b0,  16383,      0, 'h40000,      0,   53957,       0};
        tab[2] = '{1'b0,  16383,      0, 'h80000, -53957,       0,       0};
        tab[3] = '{1'b0,  16383,      0, 'hC0000,      0,  -53957,       0};
        tab[4] = '{1'b1, -12000,  12000,       0,  55892,       0, 'h60000};
        tab[5] = '{1'b0, -32768, -32768, 'h20000,      0, -131072,       0};
        tab[6] = '{1'b0,  32767,      0,       0, 107918,       0,       0};
        tab[7] = '{1'b1,  20000,      0,       0,  65870,       0,       0};
        tab[8] = '{1'b1,      0, -20000,       0,  65870,       0, -262144};
        tab[9] = '{1'b0,      0,  10000, 'h80000,      0,  -32935,       0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_out_valid", out_valid, 1'b0);
        check("reset_iout", so(iout), 0, 0);
        check("reset_qout", so(qout), 0, 0);
        check("reset_phase", int'(phase_out), 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // directed vectors, one isolated sample each
        for (int t = 0; t < 10; t++) begin
            drive(tab[t].m, tab[t].i, tab[t].q, tab[t].ph);
            idle();
            wait_out(n);
            check("tab_latency", n, LAT, 0);
            check("tab_iout", so(iout), tab[t].ei, 3);
            check("tab_qout", so(qout), tab[t].eq, 3);
            check_ph("tab_phase", phase_out, tab[t].ep);
            @(negedge clk);
            check_bit("tab_single_pulse", out_valid, 1'b0);
            check("tab_hold_iout", so(iout), tab[t].ei, 3);
        end

        // back-to-back alternating modes, then random gaps
        for (int s = 0; s < 200; s++) begin
            gen(s[0], vi, vq, vp);
            drive(s[0], vi, vq, vp);
        end
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(1) == 1) begin
                gen(s[0], vi, vq, vp);
                drive(s[0], vi, vq, vp);
            end else begin
                idle();
            end
        end
        idle();
        repeat (LAT + 4) @(posedge clk);
        check("stream_drained", exp_q.size(), 0, 0);

        // reset with 10 samples in flight
        for (int s = 0; s < 10; s++) begin
            gen(1'b0, vi, vq, vp);
            drive(1'b0, vi, vq, vp);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_bit("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_iout", so(iout), 0, 0);
        check("async_rst_qout", so(qout), 0, 0);
        check("async_rst_phase", int'(phase_out), 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        repeat (LAT + 10) begin
            @(negedge clk);
            if (out_valid === 1'b1) cnt++;
        end
        check("no_ghost_outputs", cnt, 0, 0);

        drive(1'b0, 16383, 0, 'hC0000);
        idle();
        wait_out(n);
        check("post_reset_latency", n, LAT, 0);
        check("post_reset_qout", so(qout), -53957, 3);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
